// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  modport master (
    output start, md_op, a, b, rd_sel,
    input  busy, hi, lo, result
  );

  modport slave (
    input  start, md_op, a, b, rd_sel,
    output busy, hi, lo, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; the result is computed at
// start and committed after a fixed busy period.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        res_q, res_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;

  // Datapath: full-width products and quotient/remainder from the live operands.
  always_comb begin
    prod_s = 64'($signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b}));
    prod_u = {32'b0, md.a} * {32'b0, md.b};
    b_zero = (md.b == 32'd0);
    abs_a  = md.a[31] ? 32'(-md.a) : md.a;
    abs_b  = md.b[31] ? 32'(-md.b) : md.b;
    q_mag  = b_zero ? 32'd0 : abs_a / abs_b;
    r_mag  = b_zero ? 32'd0 : abs_a % abs_b;
    // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps).
    q_s    = (md.a[31] ^ md.b[31]) ? 32'(-q_mag) : q_mag;
    r_s    = md.a[31] ? 32'(-r_mag) : r_mag;
    q_u    = b_zero ? 32'd0 : md.a / md.b;
    r_u    = b_zero ? 32'd0 : md.a % md.b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: divide-by-zero latches current HI/LO so the commit leaves them unchanged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.md_op)
            OP_MULT: begin
              res_d   = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              res_d   = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV: begin
              res_d   = b_zero ? {hi_q, lo_q} : {r_s, q_s};
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              res_d   = b_zero ? {hi_q, lo_q} : {r_u, q_u};
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = md.a;
            OP_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.busy   = (state_q == RUN);
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  assign md.result = md.rd_sel ? hi_q : lo_q;

endmodule
